// File: rtl/riscv_keypad_scanner.sv
// riscv_keypad_scanner: matrix keypad scan, per-frame debounce, press/hold/release FSM and key-event FIFO
module riscv_keypad_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int CODE_W    = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    input  logic              pop,
    input  logic              clr_ovf,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow,
    output logic              key_down,
    output logic [CODE_W-1:0] held_code
);
    localparam int DW  = $clog2(SCAN_DIV);
    localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int DBW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, RELEASE_PEND} state_t;

    logic [ROWS-1:0]   r_sync1, r_sync2;
    logic [DW-1:0]     r_dwell;
    logic [CIW-1:0]    r_col_idx;
    logic              r_found, r_frame_end, r_res_found;
    logic [CODE_W-1:0] r_best, r_res;
    logic              w_cur_found, w_frame_found;
    logic [CODE_W-1:0] w_cur_code, w_frame_code;

    state_t            r_state, w_state;
    logic [DBW-1:0]    r_cnt, w_cnt;
    logic [CODE_W-1:0] r_cand, w_cand, r_held, w_held;
    logic              w_push;

    logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wp, r_rp;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              w_full, w_empty, w_do_pop, w_do_push;

    assign col = ~(COLS'(1) << r_col_idx);

    // lowest low row in the current column; descending loop lets the lowest row win
    always_comb begin
        w_cur_found = 1'b0;
        w_cur_code  = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!r_sync2[r]) begin
                w_cur_found = 1'b1;
                w_cur_code  = CODE_W'(r * COLS + int'(r_col_idx));
            end
        end
    end

    assign w_frame_found = r_found | w_cur_found;
    assign w_frame_code  = (r_found && (!w_cur_found || r_best < w_cur_code)) ? r_best : w_cur_code;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1     <= '1;
            r_sync2     <= '1;
            r_dwell     <= '0;
            r_col_idx   <= '0;
            r_found     <= 1'b0;
            r_best      <= '0;
            r_frame_end <= 1'b0;
            r_res_found <= 1'b0;
            r_res       <= '0;
        end else begin
            r_sync1     <= row;
            r_sync2     <= r_sync1;
            r_frame_end <= 1'b0;
            if (r_dwell == DW'(SCAN_DIV - 1)) begin
                r_dwell <= '0;
                if (r_col_idx == CIW'(COLS - 1)) begin
                    r_col_idx   <= '0;
                    r_found     <= 1'b0;
                    r_frame_end <= 1'b1;
                    r_res_found <= w_frame_found;
                    r_res       <= w_frame_code;
                end else begin
                    r_col_idx <= r_col_idx + CIW'(1);
                    r_found   <= w_frame_found;
                    r_best    <= w_frame_code;
                end
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_held  <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_cand  <= w_cand;
            r_held  <= w_held;
        end
    end

    // a different key while held counts as a release; the new key is debounced from IDLE
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_cand  = r_cand;
        w_held  = r_held;
        w_push  = 1'b0;
        if (r_frame_end) begin
            case (r_state)
                IDLE: if (r_res_found) begin
                    if (DEBOUNCE == 1) begin
                        w_state = HELD;
                        w_held  = r_res;
                        w_push  = 1'b1;
                        w_cnt   = '0;
                    end else begin
                        w_state = PRESS_PEND;
                        w_cand  = r_res;
                        w_cnt   = DBW'(1);
                    end
                end
                PRESS_PEND: if (r_res_found && r_res == r_cand) begin
                    if (int'(r_cnt) + 1 >= DEBOUNCE) begin
                        w_state = HELD;
                        w_held  = r_cand;
                        w_push  = 1'b1;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + DBW'(1);
                    end
                end else begin
                    w_state = IDLE;
                    w_cnt   = '0;
                end
                HELD: if (!(r_res_found && r_res == r_held)) begin
                    w_state = (DEBOUNCE == 1) ? IDLE : RELEASE_PEND;
                    w_cnt   = (DEBOUNCE == 1) ? '0 : DBW'(1);
                end
                RELEASE_PEND: if (!(r_res_found && r_res == r_held)) begin
                    w_state = (int'(r_cnt) + 1 >= DEBOUNCE) ? IDLE : RELEASE_PEND;
                    w_cnt   = (int'(r_cnt) + 1 >= DEBOUNCE) ? '0 : r_cnt + DBW'(1);
                end else begin
                    w_state = HELD;
                    w_cnt   = '0;
                end
            endcase
        end
    end

    assign w_full    = r_count == CNT_W'(FIFO_DEPTH);
    assign w_empty   = r_count == '0;
    assign w_do_pop  = pop && !w_empty;
    assign w_do_push = w_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp] <= w_held;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_do_push) r_wp <= r_wp + AW'(1);
            if (w_do_pop) r_rp <= r_rp + AW'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
            r_ovf   <= (w_push && w_full && !w_do_pop) || (r_ovf && !clr_ovf);
        end
    end

    assign key_valid  = !w_empty;
    assign key_code   = w_empty ? '0 : r_mem[r_rp];
    assign fifo_count = r_count;
    assign overflow   = r_ovf;
    assign key_down   = (r_state == HELD) || (r_state == RELEASE_PEND);
    assign held_code  = r_held;
endmodule

// File: tb/tb_riscv_keypad_scanner.sv
// tb_riscv_keypad_scanner: keypad matrix model driving the scanner, checked frame by frame against a key-event model
module tb_riscv_keypad_scanner;
    localparam int ROWS = 4, COLS = 4, SD = 4, DB = 2, FD = 4;

    logic        clk = 1'b0, rst = 1'b0, pop = 1'b0, clr_ovf = 1'b0;
    logic [3:0]  row, col, key_code, held_code;
    logic [2:0]  fifo_count;
    logic        key_valid, overflow, key_down;
    logic [15:0] pressed = '0;

    int checks = 0, errors = 0;
    int m_state, m_cnt, m_cand, m_held;
    bit m_ovf;
    int q[$];

    riscv_keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .pop(pop), .clr_ovf(clr_ovf),
        .key_valid(key_valid), .key_code(key_code), .fifo_count(fifo_count),
        .overflow(overflow), .key_down(key_down), .held_code(held_code)
    );

    always #5 clk = ~clk;

    // a pressed key shorts its row to its column while that column is strobed low
    always_comb begin
        row = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_cand = 0; m_held = 0; m_ovf = 0;
        q.delete();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/key_down"}, int'(key_down), int'(m_state == 2 || m_state == 3));
        chk({tag, "/held_code"}, int'(held_code), m_held);
        chk({tag, "/fifo_count"}, int'(fifo_count), q.size());
        chk({tag, "/key_valid"}, int'(key_valid), int'(q.size() != 0));
        chk({tag, "/key_code"}, int'(key_code), q.size() != 0 ? q[0] : 0);
        chk({tag, "/overflow"}, int'(overflow), int'(m_ovf));
    endtask

    // states: 0 idle, 1 press pending, 2 held, 3 release pending
    task automatic model_frame(input logic [15:0] mask, input bit pop_end);
        int res = -1;
        bit push = 0;
        for (int i = 15; i >= 0; i--) if (mask[i]) res = i;
        if (m_state == 0) begin
            if (res >= 0) begin
                if (DB == 1) begin m_state = 2; m_held = res; push = 1; end
                else begin m_state = 1; m_cand = res; m_cnt = 1; end
            end
        end else if (m_state == 1) begin
            if (res == m_cand) begin
                m_cnt++;
                if (m_cnt >= DB) begin m_state = 2; m_held = m_cand; push = 1; end
            end else m_state = 0;
        end else if (m_state == 2) begin
            if (res != m_held) begin m_state = (DB == 1) ? 0 : 3; m_cnt = 1; end
        end else begin
            if (res != m_held) begin m_cnt++; if (m_cnt >= DB) m_state = 0; end
            else m_state = 2;
        end
        if (pop_end && q.size() != 0) void'(q.pop_front());
        if (push) begin
            if (q.size() < FD) q.push_back(m_held);
            else m_ovf = 1;
        end
    endtask

    // starts and ends at the dwell-1 cycle of column 0; the frame-end update lands in between
    task automatic frame(input logic [15:0] mask, input int npop = 0, input bit clr = 0,
                         input bit pop_end = 0, input string tag = "frame");
        int n = 0;
        pressed = mask;
        if (clr) begin
            clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0; m_ovf = 0; n++;
        end
        for (int i = 0; i < npop; i++) begin
            chk({tag, "/head"}, int'(key_code), q.size() != 0 ? q[0] : 0);
            pop = 1'b1; @(negedge clk); pop = 1'b0;
            if (q.size() != 0) void'(q.pop_front());
            n++;
        end
        repeat (15 - n) @(negedge clk);
        pop = pop_end;
        @(negedge clk);
        pop = 1'b0;
        model_frame(mask, pop_end);
        check_outputs(tag);
    endtask

    task automatic press(input int code, input string tag);
        frame(16'(1) << code, 0, 0, 0, tag);
        frame(16'(1) << code, 0, 0, 0, tag);
        frame('0, 0, 0, 0, tag);
        frame('0, 0, 0, 0, tag);
    endtask

    initial begin
        logic [15:0] m = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/col", int'(col), 4'hE);
        check_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("scan/col0", int'(col), 4'hE);
        for (int j = 1; j <= 4; j++) begin
            repeat (4) @(negedge clk);
            chk($sformatf("scan/col%0d", j), int'(col), int'(~(4'd1 << (j % 4)) & 4'hF));
        end
        model_frame('0, 0);

        for (int i = 0; i < 5; i++) frame(16'h0040, 0, 0, 0, "clean");
        chk("clean/code", int'(key_code), 6);
        chk("clean/held", int'(held_code), 6);
        frame('0, 0, 0, 0, "clean_rel");
        frame('0, 0, 0, 0, "clean_rel");
        chk("clean_rel/count", int'(fifo_count), 1);
        frame('0, 1, 0, 0, "drain");

        frame(16'h0040, 0, 0, 0, "bounce");
        frame('0, 0, 0, 0, "bounce");
        frame('0, 0, 0, 0, "bounce");
        chk("bounce/count", int'(fifo_count), 0);

        for (int i = 0; i < 3; i++) frame(16'h0420, 0, 0, 0, "multi");
        chk("multi/code", int'(key_code), 5);
        frame('0, 0, 0, 0, "multi_rel");
        frame('0, 1, 0, 0, "multi_rel");

        press(1, "ovf"); press(2, "ovf"); press(3, "ovf"); press(4, "ovf"); press(7, "ovf");
        chk("ovf/count", int'(fifo_count), 4);
        chk("ovf/flag", int'(overflow), 1);
        frame('0, 4, 0, 0, "ovf_pop");
        frame('0, 0, 1, 0, "ovf_clr");
        chk("ovf_clr/flag", int'(overflow), 0);
        press(8, "fill"); press(9, "fill"); press(10, "fill"); press(11, "fill");
        frame(16'h1000, 0, 0, 0, "pushpop");
        frame(16'h1000, 0, 0, 1, "pushpop");
        chk("pushpop/count", int'(fifo_count), 4);
        chk("pushpop/head", int'(key_code), 9);
        frame('0, 0, 0, 0, "pushpop_rel");
        frame('0, 0, 0, 0, "pushpop_rel");

        frame('0, 3, 0, 0, "pre_rst");
        frame(16'h0040, 0, 0, 0, "pre_rst");
        frame(16'h0040, 0, 0, 0, "pre_rst");
        chk("pre_rst/count", int'(fifo_count), 2);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        check_outputs("mid_rst");
        rst = 1'b1;
        @(negedge clk);
        frame(16'h0040, 0, 0, 0, "reaccept");
        frame(16'h0040, 0, 0, 0, "reaccept");
        chk("reaccept/code", int'(key_code), 6);
        frame('0, 0, 0, 0, "reaccept_rel");
        frame('0, 1, 0, 0, "reaccept_rel");

        for (int i = 0; i < 60; i++) begin
            int sel = $urandom_range(0, 9);
            if (sel <= 2) m = '0;
            else if (sel <= 5) m = m;
            else if (sel <= 8) m = 16'(1) << $urandom_range(0, 15);
            else m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            frame(m, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
